vga_fb_reader: RTL and testbench
================================

VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-003 SHALL have parameter FB_WIDTH, default 320, meaning frame-buffer pixels per row; rows = V_ACTIVE/2.
REQ-004 SHALL have port pclk  input  1  meaning 25 MHz pixel clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  meaning reset; one clock, reset synchronous, active-high.
REQ-006 SHALL have port fb_addr  output  17  meaning frame-buffer read address, row-major 320x240.
REQ-007 SHALL have port fb_re  output  1  meaning read enable, high for active-region fetches.
REQ-008 SHALL have port fb_dout  input  16  meaning read data, valid one pclk after fb_addr; [11:8]=R, [7:4]=G, [3:0]=B; [15:12] ignored.
REQ-009 SHALL have port vga_r, vga_g, vga_b  output  4 each  meaning pixel colour.
REQ-010 SHALL have port vga_hs, vga_vs  output  1 each  meaning syncs, active-low.
REQ-011 SHALL have port frame_start  output  1  meaning one-pclk pulse at h=0, v=0.
REQ-012 SHALL have ports marker_x  input  9 and marker_y  input  8 (present only with CROSSHAIR_EN), meaning marker position in frame-buffer coordinates.

Function
REQ-013 h_cnt SHALL count 0..799 and wrap to 0; v_cnt SHALL increment on h wrap, count 0..524, wrap to 0.
REQ-014 Horizontal: active 0-639, front porch 640-655, sync 656-751, back porch 752-799; vertical: active 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-015 fb_addr SHALL equal row_base + h_cnt[9:1] while active, else hold; no multiplier.
REQ-016 row_base SHALL reset to 0 at v wrap and add FB_WIDTH at the end of each active line with v_cnt odd, giving 2x line doubling.
REQ-017 Last active pixel (639,479) SHALL address 76799; fb_addr SHALL never exceed 76799.
REQ-018 Sync, blank and RGB for one counter position SHALL reach the pins on the same edge, exactly 2 pclk after that position; sync/blank SHALL be delayed by matching registers.
REQ-019 RGB SHALL be 0 whenever the delayed blank is set; syncs SHALL be driven during blanking only in their sync windows.
REQ-020 frame_start SHALL be aligned with the pin-side pixel (0,0), i.e. also 2 pclk latency.

Reset
REQ-021 While rst is high: h_cnt=v_cnt=0, row_base=0, fb_addr=0, fb_re=0, RGB=0, vga_hs=vga_vs=1, frame_start=0, pipeline cleared.
REQ-022 Reset asserted mid-frame SHALL abort the frame; the first pclk after release SHALL begin at position (0,0).

Configuration
REQ-023 Macro VGA_FB_READER_CROSSHAIR_EN SHALL, when defined, add marker_x/marker_y and draw a crosshair overlay.
REQ-024 With it: marker_x/marker_y SHALL be sampled once per frame at h=0, v=0; active pixels with h_cnt[9:1]==marker_x or v_cnt[8:1]==marker_y SHALL output R=F, G=0, B=0; an axis with marker_x>=320 or marker_y>=240 SHALL draw no line.
REQ-025 Without it: ports are absent and RGB comes solely from fb_dout.

Structure
REQ-026 Timing constants (active, porches, sync widths, totals, FB_WIDTH, FB_DEPTH=76800) SHALL live in shared package vga_timing_pkg.
REQ-027 Counters and sync/blank generation SHALL be sub-module vga_timing_gen; address, pipeline and overlay remain in vga_fb_reader.

Verification
REQ-028 Release reset, run 2 frames -> vga_hs low for 96 pclk every 800; vga_vs low for 2 lines every 525; frame_start period 420000 pclk.
REQ-029 fb model returns data = address[11:0] -> pixel (2,0) shows 0x001, pixel (0,2) shows 0x140 (addr 320), pixel (639,479) shows address 76799 low bits; lines 0 and 1 are identical.
REQ-030 During blanking, fb model drives 0xFFF -> RGB stays 0 and fb_re stays low.
REQ-031 Assert rst for 3 pclk at h=300, v=200 -> outputs take reset values; after release, frame_start arrives at pin-side (0,0) and fb_addr restarts at 0.
REQ-032 CROSSHAIR_EN, marker (160,120), marker changed mid-frame -> red at h=320-321 on all lines and at lines 240-241; the change takes effect only on the next frame.
REQ-033 CROSSHAIR_EN, marker_x=400 -> no vertical line; horizontal line still drawn.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared 640x480@60 timing constants, frame-buffer geometry and the small
// types carried down the pixel pipeline of vga_fb_reader.
//   VGA_H_* / VGA_V_* : active, porch, sync and total lengths in pclk / lines
//   VGA_FB_WIDTH      : frame-buffer pixels per row
//   VGA_FB_DEPTH      : frame-buffer words (320 x 240)
//   vga_ctl_t         : per-pixel sideband (blank, syncs, start-of-frame)
//   vga_rgb_t         : 4:4:4 pixel colour
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned VGA_FB_WIDTH = 320;
  localparam int unsigned VGA_FB_DEPTH = 76800;

  localparam int unsigned VGA_CNT_W  = 10;
  localparam int unsigned VGA_ADDR_W = 17;
  localparam int unsigned VGA_DATA_W = 16;
  localparam int unsigned VGA_PIX_W  = 12;

  typedef struct packed {
    logic blank;
    logic hs_n;
    logic vs_n;
    logic sof;
  } vga_ctl_t;

  localparam vga_ctl_t VGA_CTL_IDLE = '{blank: 1'b1, hs_n: 1'b1, vs_n: 1'b1, sof: 1'b0};

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_rgb_t;

  localparam vga_rgb_t VGA_RGB_BLACK  = '{r: 4'h0, g: 4'h0, b: 4'h0};
  localparam vga_rgb_t VGA_RGB_MARKER = '{r: 4'hF, g: 4'h0, b: 4'h0};

  // Frame-buffer word layout: [11:8]=R, [7:4]=G, [3:0]=B.
  function automatic vga_rgb_t vga_unpack_rgb(input logic [VGA_PIX_W-1:0] word);
    return '{r: word[11:8], g: word[7:4], b: word[3:0]};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Horizontal/vertical position counters and the raw (undelayed) sync and
// blank decode for one counter position.
//   pclk_i        : pixel clock, rising edge
//   rst_i         : synchronous active-high reset, counters held at (0,0)
//   h_cnt_o       : pixel within line, 0 .. H_TOTAL-1
//   v_cnt_o       : line within frame, 0 .. V_TOTAL-1
//   active_o      : position is inside the visible area
//   hs_n_o/vs_n_o : active-low sync windows
//   sof_o         : position (0,0)
//   line_end_o    : last visible pixel of a visible line
//   frame_end_o   : last position of the frame (next edge wraps to 0,0)
// -----------------------------------------------------------------------------
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE
) (
  input  logic                 pclk_i,
  input  logic                 rst_i,
  output logic [VGA_CNT_W-1:0] h_cnt_o,
  output logic [VGA_CNT_W-1:0] v_cnt_o,
  output logic                 active_o,
  output logic                 hs_n_o,
  output logic                 vs_n_o,
  output logic                 sof_o,
  output logic                 line_end_o,
  output logic                 frame_end_o
);

  // Blanking intervals are fixed; only the visible area scales.
  localparam int unsigned H_TOTAL = H_ACTIVE + (VGA_H_TOTAL - VGA_H_ACTIVE);
  localparam int unsigned V_TOTAL = V_ACTIVE + (VGA_V_TOTAL - VGA_V_ACTIVE);

  localparam logic [VGA_CNT_W-1:0] CNT_ONE    = VGA_CNT_W'(1);
  localparam logic [VGA_CNT_W-1:0] H_ACT_C    = VGA_CNT_W'(H_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] H_ACT_LAST = VGA_CNT_W'(H_ACTIVE - 1);
  localparam logic [VGA_CNT_W-1:0] H_SYNC_BEG = VGA_CNT_W'(H_ACTIVE + VGA_H_FP);
  localparam logic [VGA_CNT_W-1:0] H_SYNC_END = VGA_CNT_W'(H_ACTIVE + VGA_H_FP + VGA_H_SYNC);
  localparam logic [VGA_CNT_W-1:0] H_LAST     = VGA_CNT_W'(H_TOTAL - 1);
  localparam logic [VGA_CNT_W-1:0] V_ACT_C    = VGA_CNT_W'(V_ACTIVE);
  localparam logic [VGA_CNT_W-1:0] V_SYNC_BEG = VGA_CNT_W'(V_ACTIVE + VGA_V_FP);
  localparam logic [VGA_CNT_W-1:0] V_SYNC_END = VGA_CNT_W'(V_ACTIVE + VGA_V_FP + VGA_V_SYNC);
  localparam logic [VGA_CNT_W-1:0] V_LAST     = VGA_CNT_W'(V_TOTAL - 1);

  logic [VGA_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VGA_CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic                 h_wrap;

  assign h_wrap = (h_cnt_q == H_LAST);

  always_comb begin
    h_cnt_d = h_cnt_q + CNT_ONE;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge pclk_i) begin
    if (rst_i) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt_o     = h_cnt_q;
  assign v_cnt_o     = v_cnt_q;
  assign active_o    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign hs_n_o      = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q < H_SYNC_END));
  assign vs_n_o      = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q < V_SYNC_END));
  assign sof_o       = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign line_end_o  = (h_cnt_q == H_ACT_LAST) && (v_cnt_q < V_ACT_C);
  assign frame_end_o = h_wrap && (v_cnt_q == V_LAST);

endmodule

// File: rtl/vga_fb_reader.sv
// -----------------------------------------------------------------------------
// vga_fb_reader
// Scans a 320x240 frame buffer out to a 640x480 VGA raster with 2x pixel and
// line doubling. One synchronous-read fetch per visible pclk; colour, syncs,
// blank and frame_start reach the pins together, two pclk after the counter
// position that produced them.
//   pclk        : pixel clock, rising edge
//   rst         : synchronous active-high reset
//   fb_addr     : frame-buffer read address (row-major), held during blanking
//   fb_re       : read enable, high on visible positions
//   fb_dout     : read data, one pclk after fb_addr; [11:0] = RGB 4:4:4
//   vga_r/g/b   : pixel colour, forced to 0 during blanking
//   vga_hs/vs   : active-low syncs
//   frame_start : one-pclk pulse with pin-side pixel (0,0)
//   marker_x/y  : crosshair position in frame-buffer coordinates
//                 (only with VGA_FB_READER_CROSSHAIR_EN)
// Build option: define VGA_FB_READER_CROSSHAIR_EN to add the red crosshair
// overlay and its marker ports.
// -----------------------------------------------------------------------------
module vga_fb_reader
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned FB_WIDTH = VGA_FB_WIDTH
) (
  input  logic                  pclk,
  input  logic                  rst,
  output logic [VGA_ADDR_W-1:0] fb_addr,
  output logic                  fb_re,
  input  logic [VGA_DATA_W-1:0] fb_dout,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic                  frame_start
`ifdef VGA_FB_READER_CROSSHAIR_EN
  ,
  input  logic [8:0]            marker_x,
  input  logic [7:0]            marker_y
`endif
);

  localparam logic [VGA_ADDR_W-1:0] FB_W_ADDR = VGA_ADDR_W'(FB_WIDTH);

  logic [VGA_CNT_W-1:0] h_cnt;
  logic [VGA_CNT_W-1:0] v_cnt;
  logic                 active;
  logic                 hs_n;
  logic                 vs_n;
  logic                 sof;
  logic                 line_end;
  logic                 frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_timing (
    .pclk_i      (pclk),
    .rst_i       (rst),
    .h_cnt_o     (h_cnt),
    .v_cnt_o     (v_cnt),
    .active_o    (active),
    .hs_n_o      (hs_n),
    .vs_n_o      (vs_n),
    .sof_o       (sof),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  // Only [11:0] of the read word carries colour; bit 0 of h_cnt is the
  // horizontal doubling phase and is not part of the address.
  logic unused_bits;
  assign unused_bits = ^{fb_dout[15:12], h_cnt[0], v_cnt};

  // ---------------------------------------------------------------------------
  // Address generation: row_base steps by one buffer row after every odd
  // visible line, so each buffer row is scanned twice. Adder only.
  // ---------------------------------------------------------------------------
  logic [VGA_ADDR_W-1:0] row_base_q, row_base_d;
  logic [VGA_ADDR_W-1:0] addr_hold_q, addr_hold_d;
  logic [VGA_ADDR_W-1:0] pix_addr;

  assign pix_addr = row_base_q + {{(VGA_ADDR_W - 9){1'b0}}, h_cnt[9:1]};

  always_comb begin
    row_base_d = row_base_q;
    if (frame_end) begin
      row_base_d = '0;
    end else if (line_end && v_cnt[0]) begin
      row_base_d = row_base_q + FB_W_ADDR;
    end
  end

  always_comb begin
    addr_hold_d = addr_hold_q;
    if (active) begin
      addr_hold_d = pix_addr;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      row_base_q  <= '0;
      addr_hold_q <= '0;
    end else begin
      row_base_q  <= row_base_d;
      addr_hold_q <= addr_hold_d;
    end
  end

  // The address is presented in the same cycle as its counter position so
  // the synchronous read returns data one pclk later, leaving exactly one
  // register stage for colour. Gating with rst keeps the bus quiet while
  // the counters sit at the visible position (0,0) during reset.
  always_comb begin
    fb_addr = addr_hold_q;
    fb_re   = 1'b0;
    if (rst) begin
      fb_addr = '0;
    end else if (active) begin
      fb_addr = pix_addr;
      fb_re   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Crosshair overlay
  // ---------------------------------------------------------------------------
  logic overlay_hit;

`ifdef VGA_FB_READER_CROSSHAIR_EN
  localparam logic [8:0] FB_W_X    = 9'(FB_WIDTH);
  localparam logic [7:0] FB_ROWS_Y = 8'(V_ACTIVE / 2);

  logic [8:0] mark_x_q, mark_x_d, mark_x_eff;
  logic [7:0] mark_y_q, mark_y_d, mark_y_eff;
  logic       hit_x;
  logic       hit_y;

  // The marker is latched at (0,0); that first pixel uses the live port
  // value so the whole frame sees one consistent position.
  assign mark_x_eff = sof ? marker_x : mark_x_q;
  assign mark_y_eff = sof ? marker_y : mark_y_q;

  always_comb begin
    mark_x_d = mark_x_q;
    mark_y_d = mark_y_q;
    if (sof) begin
      mark_x_d = marker_x;
      mark_y_d = marker_y;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      mark_x_q <= '1;
      mark_y_q <= '1;
    end else begin
      mark_x_q <= mark_x_d;
      mark_y_q <= mark_y_d;
    end
  end

  // An out-of-range coordinate suppresses that axis only.
  assign hit_x       = (mark_x_eff < FB_W_X) && (h_cnt[9:1] == mark_x_eff);
  assign hit_y       = (mark_y_eff < FB_ROWS_Y) && (v_cnt[8:1] == mark_y_eff);
  assign overlay_hit = active && (hit_x || hit_y);
`else
  assign overlay_hit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output pipeline. Stage 1 waits alongside the memory read; stage 2 is the
  // pin register where colour is chosen from the data that just arrived.
  // ---------------------------------------------------------------------------
  vga_ctl_t ctl_s1_q, ctl_s1_d;
  vga_ctl_t ctl_s2_q;
  logic     hit_s1_q;
  vga_rgb_t rgb_q, rgb_d;

  always_comb begin
    ctl_s1_d       = VGA_CTL_IDLE;
    ctl_s1_d.blank = !active;
    ctl_s1_d.hs_n  = hs_n;
    ctl_s1_d.vs_n  = vs_n;
    ctl_s1_d.sof   = sof;
  end

  always_comb begin
    rgb_d = VGA_RGB_BLACK;
    if (!ctl_s1_q.blank) begin
      rgb_d = hit_s1_q ? VGA_RGB_MARKER : vga_unpack_rgb(fb_dout[VGA_PIX_W-1:0]);
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      ctl_s1_q <= VGA_CTL_IDLE;
      ctl_s2_q <= VGA_CTL_IDLE;
      hit_s1_q <= 1'b0;
      rgb_q    <= VGA_RGB_BLACK;
    end else begin
      ctl_s1_q <= ctl_s1_d;
      ctl_s2_q <= ctl_s1_q;
      hit_s1_q <= overlay_hit;
      rgb_q    <= rgb_d;
    end
  end

  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign vga_hs      = ctl_s2_q.hs_n;
  assign vga_vs      = ctl_s2_q.vs_n;
  assign frame_start = ctl_s2_q.sof;

endmodule

// File: tb/tb_vga_fb_reader.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_reader
// Scaled-down raster (64x48 visible, same porches and sync widths) so several
// frames fit in a short run. The reference model works on a linear pixel
// index within the frame and derives every pin from the raster rules.
// -----------------------------------------------------------------------------
module tb_vga_fb_reader;

  localparam int H_ACT = 64;
  localparam int V_ACT = 48;
  localparam int FBW   = 32;
  localparam int FB_ROWS = V_ACT / 2;
  localparam int H_TOT = H_ACT + 16 + 96 + 48;
  localparam int V_TOT = V_ACT + 10 + 2 + 33;
  localparam int FRAME = H_TOT * V_TOT;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [16:0] fb_addr;
  logic        fb_re;
  logic [15:0] fb_dout = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;
`ifdef VGA_FB_READER_CROSSHAIR_EN
  logic [8:0]  marker_x = '0;
  logic [7:0]  marker_y = '0;
`endif

  always #20 pclk = ~pclk;

  vga_fb_reader #(
    .H_ACTIVE (H_ACT),
    .V_ACTIVE (V_ACT),
    .FB_WIDTH (FBW)
  ) u_dut (
    .pclk        (pclk),
    .rst         (rst),
    .fb_addr     (fb_addr),
    .fb_re       (fb_re),
    .fb_dout     (fb_dout),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .frame_start (frame_start)
`ifdef VGA_FB_READER_CROSSHAIR_EN
    ,
    .marker_x    (marker_x),
    .marker_y    (marker_y)
`endif
  );

  // Frame-buffer model: word = address low bits, junk upper nibble;
  // all-ones colour when not reading so blanking leaks are visible.
  always @(posedge pclk) begin
    if (fb_re) fb_dout <= {4'($urandom), fb_addr[11:0]};
    else       fb_dout <= {4'($urandom), 12'hFFF};
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_active(input int p);
    return ((p % H_TOT) < H_ACT) && ((p / H_TOT) < V_ACT);
  endfunction

  function automatic logic [16:0] addr_of(input int p);
    return 17'(((p / H_TOT) / 2) * FBW + (p % H_TOT) / 2);
  endfunction

  // {hs, vs, frame_start, r, g, b}
  function automatic logic [14:0] pins_of(input int p, input int mx, input int my);
    int h, v;
    logic hs, vs, fs;
    logic [11:0] rgb;
    logic [16:0] a;
    h   = p % H_TOT;
    v   = p / H_TOT;
    hs  = !((h >= H_ACT + 16) && (h < H_ACT + 16 + 96));
    vs  = !((v >= V_ACT + 10) && (v < V_ACT + 12));
    fs  = (p == 0);
    rgb = 12'h000;
    if (is_active(p)) begin
      a   = addr_of(p);
      rgb = a[11:0];
      if ((mx < FBW && h / 2 == mx) || (my < FB_ROWS && v / 2 == my)) rgb = 12'hF00;
    end
    return {hs, vs, fs, rgb};
  endfunction

  localparam logic [14:0] PINS_IDLE = {1'b1, 1'b1, 1'b0, 12'h000};

  typedef struct {
    bit          rst;
    int          pos;
    logic [14:0] pins;
  } entry_t;

  entry_t      e_prev, e_cur;
  int          pos = 0;
  bit          rst_cur = 1'b1;
  logic [16:0] last_addr = '0;
  int          cur_mx = 1000, cur_my = 1000;
  int          drv_mx = 1000, drv_my = 1000;
  int          lat_mx = 1000, lat_my = 1000;
  int          cyc = 0;
  int          hs_run = -1, vs_run = -1;
  int          last_fs = -1, rel_cyc = -1;

  task automatic step(input bit r);
    logic [14:0] exp_pins;
    logic [14:0] got_pins;
    bit          exp_re;
    logic [16:0] exp_addr;
    @(posedge pclk);
    e_prev = e_cur;
    e_cur.rst = rst_cur;
    e_cur.pos = pos;
    e_cur.pins = PINS_IDLE;
    if (!rst_cur) begin
      if (pos == 0) begin
        lat_mx = drv_mx;
        lat_my = drv_my;
      end
      e_cur.pins = pins_of(pos, lat_mx, lat_my);
      if (is_active(pos)) last_addr = addr_of(pos);
      pos = (pos + 1) % FRAME;
    end else begin
      pos = 0;
      last_addr = '0;
    end
    cyc++;
    #1;
    if (rst_cur && !r) rel_cyc = cyc;
    rst = r;
    rst_cur = r;
    drv_mx = cur_mx;
    drv_my = cur_my;
`ifdef VGA_FB_READER_CROSSHAIR_EN
    marker_x = 9'(cur_mx);
    marker_y = 8'(cur_my);
`endif
    #1;
    exp_pins = (e_cur.rst || e_prev.rst) ? PINS_IDLE : e_prev.pins;
    got_pins = {vga_hs, vga_vs, frame_start, vga_r, vga_g, vga_b};
    check($sformatf("pins h=%0d v=%0d", e_prev.pos % H_TOT, e_prev.pos / H_TOT),
          {17'b0, got_pins}, {17'b0, exp_pins});
    if (rst_cur)               begin exp_re = 1'b0; exp_addr = '0;           end
    else if (is_active(pos))   begin exp_re = 1'b1; exp_addr = addr_of(pos); end
    else                       begin exp_re = 1'b0; exp_addr = last_addr;    end
    check($sformatf("fb_re h=%0d v=%0d", pos % H_TOT, pos / H_TOT), {31'b0, fb_re}, {31'b0, exp_re});
    check($sformatf("fb_addr h=%0d v=%0d", pos % H_TOT, pos / H_TOT), {15'b0, fb_addr}, {15'b0, exp_addr});

    // Pulse-width and period measurements on the pins.
    if (rst_cur) begin
      hs_run = -1; vs_run = -1; last_fs = -1;
    end
    if (vga_hs === 1'b0) begin
      if (hs_run >= 0) hs_run++;
    end else begin
      if (hs_run > 0) check("hs_width", 32'(hs_run), 32'd96);
      hs_run = 0;
    end
    if (vga_vs === 1'b0) begin
      if (vs_run >= 0) vs_run++;
    end else begin
      if (vs_run > 0) check("vs_width", 32'(vs_run), 32'(2 * H_TOT));
      vs_run = 0;
    end
    if (frame_start === 1'b1) begin
      if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(FRAME));
      if (rel_cyc >= 0) begin
        check("fs_after_release", 32'(cyc - rel_cyc), 32'd2);
        rel_cyc = -1;
      end
      last_fs = cyc;
    end
  endtask

  initial begin
    int tgt, i;
    bit hit;
    e_cur.rst = 1'b1;  e_cur.pos = 0;  e_cur.pins = PINS_IDLE;
    e_prev = e_cur;

`ifdef VGA_FB_READER_CROSSHAIR_EN
    cur_mx = FBW / 2;
    cur_my = FB_ROWS / 2;
`endif
    repeat (4) step(1'b1);

    // Two full frames plus a margin from reset release.
    for (int n = 0; n < 2 * FRAME + 8; n++) begin
`ifdef VGA_FB_READER_CROSSHAIR_EN
      if (n == FRAME / 2) begin
        cur_mx = $urandom_range(0, FBW - 1);
        cur_my = $urandom_range(0, FB_ROWS - 1);
      end
      if (n == FRAME + FRAME / 3) begin
        cur_mx = $urandom_range(FBW, 511);
        cur_my = $urandom_range(0, FB_ROWS - 1);
      end
`endif
      step(1'b0);
    end

    // Mid-frame reset at a random visible position.
    tgt = $urandom_range(2, V_ACT - 1) * H_TOT + $urandom_range(0, H_ACT - 1);
    hit = 1'b0;
    i = 0;
    while (!hit && i < FRAME + 2) begin
      if (pos == tgt) hit = 1'b1;
      else step(1'b0);
      i++;
    end
    check("reach_reset_point", {31'b0, hit}, 32'd1);
    repeat (3) step(1'b1);

    for (int n = 0; n < FRAME + 8; n++) step(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
